// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and grant-select constants for the memory port arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_I = 3'd1,
    ST_ISSUE_D = 3'd2,
    ST_WAIT_I  = 3'd3,
    ST_WAIT_D  = 3'd4,
    ST_ERR_D   = 3'd5
  } state_e;

  // Grant select: which requester owns the access started in IDLE.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants made while fetch was waiting.
// Latency: count updates on the clock edge after inc/clr; at_max is combinational from the count.
// Backpressure: none; clr has priority over inc, inc is ignored once at_max.
// Ports: clk, rst (sync active-low), inc, clr in; at_max out (count == MAX).
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int CW  = 3,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mem_system between instruction fetch and the memory stage (one access at a time).
// Latency: grant cycle -> 1-cycle Rd/Wr issue -> wait for Done; ack in the Done cycle (min 3 cycles).
// Backpressure: requesters hold level requests; the one not being served sees *_stall until its ack.
// Ports: clk, rst (sync active-low); fetch i_req/i_addr -> i_ack/i_rdata/i_stall;
//        data d_rd/d_wr/d_addr/d_wdata -> d_ack/d_rdata/d_stall;
//        mem_addr/mem_wdata/mem_rd/mem_wr out, mem_rdata/mem_done/mem_err in; err out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        starve_inc, starve_clr, starve_at_max;
  logic        d_req, gnt_sel;

  arb_starve_ctr #(.CW(CW), .MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // A data request is valid only when exactly one of rd/wr is asserted.
  assign d_req     = d_rd ^ d_wr;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_stall   = i_req & ~i_ack;
  assign d_stall   = (d_rd | d_wr) & ~d_ack;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    gnt_sel    = REQ_I;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    i_ack      = 1'b0;
    i_rdata    = '0;
    d_ack      = 1'b0;
    d_rdata    = '0;
    err        = mem_err;

    unique case (state_q)
      ST_IDLE: begin
        if (d_rd && d_wr) err = 1'b1;
        if (mem_done)     err = 1'b1;
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        if (d_req && !(i_req && starve_at_max)) gnt_sel = REQ_D;
        if (gnt_sel == REQ_D) begin
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          wr_d       = d_wr;
          starve_inc = i_req;
          starve_clr = ~i_req;
          state_d    = d_addr[0] ? ST_ERR_D : ST_ISSUE_D;
        end else if (i_req) begin
          addr_d     = i_addr;
          wdata_d    = '0;
          wr_d       = 1'b0;
          starve_clr = 1'b1;
          state_d    = ST_ISSUE_I;
        end else begin
          starve_clr = 1'b1;
        end
      end
      ST_ISSUE_I: begin
        mem_rd  = 1'b1;
        if (mem_done) err = 1'b1;
        state_d = ST_WAIT_I;
      end
      ST_ISSUE_D: begin
        mem_rd  = ~wr_q;
        mem_wr  = wr_q;
        if (mem_done) err = 1'b1;
        state_d = ST_WAIT_D;
      end
      ST_WAIT_I: begin
        if (mem_done) begin
          i_ack   = 1'b1;
          i_rdata = mem_rdata;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_D: begin
        if (mem_done) begin
          d_ack   = 1'b1;
          d_rdata = mem_rdata;
          state_d = ST_IDLE;
        end
      end
      ST_ERR_D: begin
        // Misaligned access: completed with an error, never reaches memory.
        err     = 1'b1;
        d_ack   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // While reset is asserted nothing may be issued or acknowledged, even
    // if mem_done arrives for an access that reset is abandoning.
    if (!rst) begin
      state_d    = ST_IDLE;
      starve_inc = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      i_ack      = 1'b0;
      i_rdata    = '0;
      d_ack      = 1'b0;
      d_rdata    = '0;
      err        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner-case sequences, random traffic.
// Latency: n/a.
// Backpressure: the bench plays both requesters and the memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        i_stall;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done, mem_err;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_req = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0; mem_err = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset (arbiter idle).
  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic        ireq, drd, dwr;
    logic [15:0] daddr, dwdata;
    logic        e_err0;              // err in the grant cycle
    logic        e_rd, e_wr;          // pulses in the following cycle
    logic [15:0] e_addr;
    logic        e_dack, e_err1;
  } vec_t;

  vec_t vt [9];

  // Random-phase model state: one outstanding access, described by timestamps.
  int          starve, t_kind, t_issue, t_done;  // t_kind: 0 none, 1 fetch, 2 data, 3 misaligned data
  logic [15:0] t_addr, t_wdata, rd_val;
  logic        t_wr;
  logic        e_rd, e_wr, e_iack, e_dack, e_err, prev_iack, prev_dack;

  initial begin
    // ---------- reset with fetch pending, then lone fetch ----------
    idle_in();
    rst = 1'b0; i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_outs", {mem_rd, mem_wr, i_ack, d_ack, err}, 5'b0);
      chk("rst_istall", i_stall, 1'b1);
      nxt();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rel_c1_rd", mem_rd, 1'b0);
    nxt();
    @(negedge clk);
    chk("rel_c2_rd", mem_rd, 1'b1);
    chk("fetch_addr", mem_addr, 16'h0010);
    nxt();
    mem_done = 1'b1; mem_rdata = 16'hA5A5;
    @(negedge clk);
    chk("fetch_ack", {i_ack, d_ack, i_stall}, 3'b100);
    chk("fetch_rdata", i_rdata, 16'hA5A5);
    chk("fetch_hold_addr", mem_addr, 16'h0010);

    // ---------- vector table: one grant decision from idle ----------
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0204, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0204, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 16'h0200, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b1, 16'h0303, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    for (int v = 0; v < 9; v++) begin
      nxt();
      do_reset();
      i_req = vt[v].ireq; i_addr = 16'h0010;
      d_rd = vt[v].drd; d_wr = vt[v].dwr; d_addr = vt[v].daddr; d_wdata = vt[v].dwdata;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", v), {mem_rd, mem_wr, i_ack, d_ack, err},
          {4'b0000, vt[v].e_err0});
      nxt();
      @(negedge clk);
      chk($sformatf("vec%0d_next", v), {mem_rd, mem_wr, d_ack, err},
          {vt[v].e_rd, vt[v].e_wr, vt[v].e_dack, vt[v].e_err1});
      chk($sformatf("vec%0d_stall", v), {i_stall, d_stall},
          {vt[v].ireq, (vt[v].drd | vt[v].dwr) & ~vt[v].e_dack});
      if (vt[v].e_rd | vt[v].e_wr) chk($sformatf("vec%0d_addr", v), mem_addr, vt[v].e_addr);
      if (vt[v].e_wr) chk($sformatf("vec%0d_wdata", v), mem_wdata, vt[v].dwdata);
      if (vt[v].e_dack) chk($sformatf("vec%0d_rdata0", v), d_rdata, 16'h0000);
    end

    // ---------- contention: data first, fetch 2 cycles after d_ack ----------
    nxt();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0010; d_rd = 1'b1; d_addr = 16'h0200;
    @(negedge clk);
    chk("cont_c0", {mem_rd, i_stall, d_stall}, 3'b011);
    nxt();
    @(negedge clk);
    chk("cont_c1", {mem_rd, mem_wr, i_stall}, 3'b101);
    chk("cont_c1_addr", mem_addr, 16'h0200);
    nxt();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    chk("cont_c2", {d_ack, i_ack, i_stall}, 3'b101);
    chk("cont_c2_rdata", d_rdata, 16'h5A5A);
    nxt();
    mem_done = 1'b0; d_rd = 1'b0;
    @(negedge clk);
    chk("cont_c3", {mem_rd, i_stall}, 2'b01);
    nxt();
    @(negedge clk);
    chk("cont_c4", {mem_rd, i_stall}, 2'b11);
    chk("cont_c4_addr", mem_addr, 16'h0010);
    nxt();
    mem_done = 1'b1; mem_rdata = 16'h0F0F;
    @(negedge clk);
    chk("cont_c5", {i_ack, i_stall}, 2'b10);
    chk("cont_c5_rdata", i_rdata, 16'h0F0F);

    // ---------- starvation: 4 writes, then a fetch, repeating ----------
    nxt();
    do_reset();
    begin
      int          npulse;
      logic        pend;
      logic [9:0]  kinds;
      npulse = 0; pend = 1'b0; kinds = '0;
      i_req = 1'b1; i_addr = 16'h0040; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
      for (int k = 0; k < 60 && npulse < 10; k++) begin
        if (k > 0) nxt();
        mem_done = pend; pend = 1'b0;
        @(negedge clk);
        if (mem_rd | mem_wr) begin
          kinds[npulse] = mem_rd;
          npulse++;
          pend = 1'b1;
        end
      end
      chk("starve_npulse", npulse, 10);
      chk("starve_order", kinds, 10'b10000_10000);
    end

    // ---------- misaligned read ----------
    nxt();
    do_reset();
    d_rd = 1'b1; d_addr = 16'h0101;
    @(negedge clk);
    chk("mis_c0", {mem_rd, d_ack, err}, 3'b000);
    nxt();
    @(negedge clk);
    chk("mis_c1", {mem_rd, mem_wr, d_ack, err}, 4'b0011);
    chk("mis_rdata", d_rdata, 16'h0000);

    // ---------- reset during the data wait ----------
    nxt();
    do_reset();
    d_rd = 1'b1; d_addr = 16'h0300;
    nxt();
    @(negedge clk);
    chk("mid_issue", mem_rd, 1'b1);
    nxt();
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    chk("mid_rst_noack", {mem_rd, mem_wr, d_ack, err}, 4'b0000);
    nxt();
    mem_done = 1'b0; d_rd = 1'b0;
    @(negedge clk);
    chk("mid_rst_hold", {mem_rd, mem_wr, d_ack}, 3'b000);
    nxt();
    rst = 1'b1; i_req = 1'b1; i_addr = 16'h0020;
    @(negedge clk);
    chk("mid_idle_grant", {mem_rd, d_ack}, 2'b00);
    nxt();
    @(negedge clk);
    chk("mid_after_issue", {mem_rd, d_ack}, 2'b10);
    chk("mid_after_addr", mem_addr, 16'h0020);

    // ---------- stray Done and mem_err ----------
    nxt();
    do_reset();
    mem_done = 1'b1;
    @(negedge clk);
    chk("stray_done", {err, i_ack, d_ack}, 3'b100);
    nxt();
    mem_done = 1'b0; mem_err = 1'b1;
    @(negedge clk);
    chk("mem_err", err, 1'b1);
    nxt();
    mem_err = 1'b0;
    @(negedge clk);
    chk("err_clear", err, 1'b0);

    // ---------- random traffic against a timestamp model ----------
    nxt();
    do_reset();
    starve = 0; t_kind = 0; t_issue = 0; t_done = 0;
    t_addr = '0; t_wdata = '0; t_wr = 1'b0;
    prev_iack = 1'b0; prev_dack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) nxt();
      // requesters: new request after ack or when idle, occasional abandon
      if (!i_req || prev_iack) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 16'($urandom) & 16'hFFFE;
      end else if ($urandom_range(0, 19) == 0) begin
        i_req = 1'b0;
      end
      if (!(d_rd | d_wr) || prev_dack) begin
        int r;
        r = $urandom_range(0, 3);
        d_rd    = (r == 1) || (r == 2);
        d_wr    = (r == 3);
        d_addr  = 16'($urandom);
        d_addr[0] = ($urandom_range(0, 7) == 0);
        d_wdata = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        d_rd = 1'b0; d_wr = 1'b0;
      end
      rd_val    = 16'($urandom);
      mem_rdata = rd_val;
      mem_done  = (t_kind == 1 || t_kind == 2) && (c == t_done);
      mem_err   = 1'b0;

      e_rd = 1'b0; e_wr = 1'b0; e_iack = 1'b0; e_dack = 1'b0; e_err = 1'b0;
      if (t_kind == 0) begin
        if ((d_rd ^ d_wr) && !(i_req && starve == 4)) begin
          starve  = i_req ? ((starve < 4) ? starve + 1 : 4) : 0;
          t_kind  = d_addr[0] ? 3 : 2;
          t_addr  = d_addr; t_wdata = d_wdata; t_wr = d_wr;
          t_issue = c + 1;
        end else if (i_req) begin
          starve  = 0;
          t_kind  = 1; t_addr = i_addr; t_wr = 1'b0;
          t_issue = c + 1;
        end else begin
          starve = 0;
        end
      end else if (c == t_issue) begin
        if (t_kind == 3) begin
          e_dack = 1'b1; e_err = 1'b1; t_kind = 0;
        end else begin
          e_rd   = (t_kind == 1) || !t_wr;
          e_wr   = (t_kind == 2) && t_wr;
          t_done = c + 1 + $urandom_range(0, 2);
        end
      end else if (c == t_done) begin
        if (t_kind == 1) e_iack = 1'b1;
        else             e_dack = 1'b1;
        t_kind = 0;
      end

      @(negedge clk);
      chk("rand_ctl", {mem_rd, mem_wr, i_ack, d_ack, err, i_stall, d_stall},
          {e_rd, e_wr, e_iack, e_dack, e_err, i_req & ~e_iack, (d_rd | d_wr) & ~e_dack});
      if (e_rd | e_wr) chk("rand_addr", mem_addr, t_addr);
      if (e_wr)        chk("rand_wdata", mem_wdata, t_wdata);
      if (e_iack)      chk("rand_irdata", i_rdata, rd_val);
      if (e_dack)      chk("rand_drdata", d_rdata, (t_addr[0]) ? 16'h0000 : rd_val);
      prev_iack = e_iack;
      prev_dack = e_dack;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
